fetch_controller: RTL and testbench

Sequences the per-core program counter register and instruction-cache read port in the multicore pipeline. Each cycle it picks the next PC: sequential, branch, jump, hold, or halt. It drives the PC register's `pc_incr`/`pc_comb` inputs and `iREN`, flushes the IF/ID latch on redirects, and holds a redirect that arrives while an I-cache miss is outstanding.

---
 rtl/fetch_controller_if.sv | 35 +++
 rtl/fetch_controller.sv | 137 +++++++++++++
 tb/tb_fetch_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle between the fetch controller, the PC register and the I-cache port.
// master = fetch controller, slave = the pipeline/cache side.
interface fetch_controller_if;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_incr;
    logic [31:0] pc_comb;
    logic        iREN;
    logic        ihit;
    logic        stall;
    logic        br_take;
    logic [31:0] br_target;
    logic        jmp_take;
    logic [31:0] jmp_target;
    logic        halt;
    logic        flush;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;

    modport master (
        input  pc, next_pc, ihit, stall, br_take, br_target,
               jmp_take, jmp_target, halt,
        output pc_incr, pc_comb, iREN, flush, fetch_valid, halted,
               fetch_count, redirect_count
    );

    modport slave (
        output pc, next_pc, ihit, stall, br_take, br_target,
               jmp_take, jmp_target, halt,
        input  pc_incr, pc_comb, iREN, flush, fetch_valid, halted,
               fetch_count, redirect_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Per-core fetch sequencer: picks the next PC (sequential/branch/jump/hold/halt),
// drives the I-cache read enable and holds a redirect across an I-cache miss.
module fetch_controller #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic CLK,
    input  logic RST,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, PEND, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] hold_target_q, hold_target_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    logic        pc_incr;
    logic [31:0] pc_comb;
    logic        iren;
    logic        flush;
    logic        fetch_valid;
    logic        halted;

    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        redirect;
    logic [31:0] redirect_tgt;

    // Targets are word-aligned before they are used or captured.
    assign br_tgt       = bus.br_target  & ~32'h3;
    assign jmp_tgt      = bus.jmp_target & ~32'h3;
    assign redirect     = bus.br_take | bus.jmp_take;
    assign redirect_tgt = bus.br_take ? br_tgt : jmp_tgt;

    always_comb begin
        state_d          = state_q;
        hold_target_d    = hold_target_q;
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        pc_incr          = 1'b0;
        pc_comb          = PC_RESET;
        iren             = 1'b0;
        flush            = 1'b0;
        fetch_valid      = 1'b0;
        halted           = 1'b0;

        if (RST) begin
            state_d          = IDLE;
            hold_target_d    = PC_RESET;
            fetch_count_d    = '0;
            redirect_count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end

                FETCH: begin
                    iren = 1'b1;
                    if (bus.halt) begin
                        flush   = 1'b1;
                        state_d = HALT;
                    end else if (bus.stall) begin
                        // Redirect sources keep their request up until stall drops.
                    end else if (redirect) begin
                        flush = 1'b1;
                        if (bus.ihit) begin
                            pc_incr          = 1'b1;
                            pc_comb          = redirect_tgt;
                            redirect_count_d = redirect_count_q + 32'd1;
                        end else begin
                            hold_target_d = redirect_tgt;
                            state_d       = PEND;
                        end
                    end else if (bus.ihit) begin
                        pc_incr       = 1'b1;
                        pc_comb       = bus.next_pc;
                        fetch_valid   = 1'b1;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end

                PEND: begin
                    // Keep reading the unchanged pc so the outstanding miss completes.
                    iren = 1'b1;
                    if (bus.halt) begin
                        flush   = 1'b1;
                        state_d = HALT;
                    end else if (!bus.stall) begin
                        if (bus.ihit) begin
                            pc_incr          = 1'b1;
                            pc_comb          = bus.br_take ? br_tgt : hold_target_q;
                            flush            = 1'b1;
                            redirect_count_d = redirect_count_q + 32'd1;
                            state_d          = FETCH;
                        end else if (bus.br_take) begin
                            hold_target_d = br_tgt;
                        end
                    end
                end

                HALT: begin
                    halted = 1'b1;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= IDLE;
            hold_target_q    <= PC_RESET;
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            hold_target_q    <= hold_target_d;
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign bus.pc_incr        = pc_incr;
    assign bus.pc_comb        = pc_comb;
    assign bus.iREN           = iren;
    assign bus.flush          = flush;
    assign bus.fetch_valid    = fetch_valid;
    assign bus.halted         = halted;
    assign bus.fetch_count    = fetch_count_q;
    assign bus.redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller (core-1 reset PC 0x200) with a small PC register model.
module tb_fetch_controller;

    localparam logic [31:0] PC_RST = 32'h0000_0200;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    fetch_controller_if bus ();

    fetch_controller #(.PC_RESET(PC_RST)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // PC register the controller steers.
    always_ff @(posedge CLK) begin
        if (RST)              bus.pc <= PC_RST;
        else if (bus.pc_incr) bus.pc <= bus.pc_comb;
    end
    assign bus.next_pc = bus.pc + 32'd4;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs just after the falling edge, then let outputs settle.
    task automatic drive(input logic ih, input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic hl);
        bus.ihit       = ih;
        bus.stall      = st;
        bus.br_take    = br;
        bus.br_target  = bt;
        bus.jmp_take   = jp;
        bus.jmp_target = jt;
        bus.halt       = hl;
        #1;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Held in reset
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst_pc_incr", 32'(bus.pc_incr), 0);
        check("rst_pc_comb", bus.pc_comb, PC_RST);
        check("rst_iren", 32'(bus.iREN), 0);
        check("rst_flush", 32'(bus.flush), 0);
        check("rst_fv", 32'(bus.fetch_valid), 0);
        check("rst_halted", 32'(bus.halted), 0);
        check("rst_fc", bus.fetch_count, 0);
        check("rst_rc", bus.redirect_count, 0);

        // IDLE cycle after reset release
        RST = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        check("idle_iren", 32'(bus.iREN), 0);
        check("idle_pc_incr", 32'(bus.pc_incr), 0);
        check("idle_pc_comb", bus.pc_comb, PC_RST);
        tick();

        // Three sequential hits
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            check("seq_iren", 32'(bus.iREN), 1);
            check("seq_pc_incr", 32'(bus.pc_incr), 1);
            check("seq_pc_comb", bus.pc_comb, 32'h204 + 32'(4 * i));
            check("seq_fv", 32'(bus.fetch_valid), 1);
            tick();
        end

        // Branch beats jump; target aligned
        drive(1, 0, 1, 32'h1003, 1, 32'h500, 0);
        check("seq_fc3", bus.fetch_count, 3);
        check("br_pc_incr", 32'(bus.pc_incr), 1);
        check("br_pc_comb", bus.pc_comb, 32'h1000);
        check("br_flush", 32'(bus.flush), 1);
        check("br_fv", 32'(bus.fetch_valid), 0);
        tick();

        // Jump on a miss -> PEND
        drive(0, 0, 0, 0, 1, 32'h40, 0);
        check("br_rc1", bus.redirect_count, 1);
        check("br_fc_same", bus.fetch_count, 3);
        check("cap_flush", 32'(bus.flush), 1);
        check("cap_pc_incr", 32'(bus.pc_incr), 0);
        check("cap_iren", 32'(bus.iREN), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pend1_pc_incr", 32'(bus.pc_incr), 0);
        check("pend1_flush", 32'(bus.flush), 0);
        check("pend1_iren", 32'(bus.iREN), 1);
        tick();
        drive(0, 0, 1, 32'h80, 0, 0, 0);
        check("pend2_pc_incr", 32'(bus.pc_incr), 0);
        check("pend2_flush", 32'(bus.flush), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("pend3_pc_incr", 32'(bus.pc_incr), 0);
        check("pend3_fv", 32'(bus.fetch_valid), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        check("apply_pc_incr", 32'(bus.pc_incr), 1);
        check("apply_pc_comb", bus.pc_comb, 32'h80);
        check("apply_flush", 32'(bus.flush), 1);
        check("apply_fv", 32'(bus.fetch_valid), 0);
        tick();

        // Stall freezes fetch and defers the branch
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 32'h300, 0, 0, 0);
            check("stall_pc_incr", 32'(bus.pc_incr), 0);
            check("stall_fv", 32'(bus.fetch_valid), 0);
            check("stall_flush", 32'(bus.flush), 0);
            check("stall_rc", bus.redirect_count, 2);
            tick();
        end
        drive(1, 0, 1, 32'h300, 0, 0, 0);
        check("unstall_pc_incr", 32'(bus.pc_incr), 1);
        check("unstall_pc_comb", bus.pc_comb, 32'h300);
        check("unstall_flush", 32'(bus.flush), 1);
        tick();

        // Halt while a redirect is pending
        drive(0, 0, 0, 0, 1, 32'h600, 0);
        check("unstall_rc3", bus.redirect_count, 3);
        check("cap2_flush", 32'(bus.flush), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        check("phalt_flush", 32'(bus.flush), 1);
        check("phalt_iren", 32'(bus.iREN), 1);
        check("phalt_halted", 32'(bus.halted), 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 32'h900, 0, 0, 0);
            check("halt_halted", 32'(bus.halted), 1);
            check("halt_iren", 32'(bus.iREN), 0);
            check("halt_pc_incr", 32'(bus.pc_incr), 0);
            check("halt_flush", 32'(bus.flush), 0);
            tick();
        end
        check("halt_pc_kept", bus.pc, 32'h300);
        check("halt_rc", bus.redirect_count, 3);

        // Reset out of HALT, enter PEND, then reset mid-miss
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h40, 0);
        check("r2_cap_flush", 32'(bus.flush), 1);
        tick();
        RST = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rp_pc_incr", 32'(bus.pc_incr), 0);
        check("rp_pc_comb", bus.pc_comb, PC_RST);
        check("rp_iren", 32'(bus.iREN), 0);
        check("rp_flush", 32'(bus.flush), 0);
        check("rp_halted", 32'(bus.halted), 0);
        tick();
        RST = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rp_idle_iren", 32'(bus.iREN), 0);
        check("rp_idle_pc_incr", 32'(bus.pc_incr), 0);
        check("rp_fc0", bus.fetch_count, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rp_hit_pc_comb", bus.pc_comb, 32'h204);
        check("rp_hit_fv", 32'(bus.fetch_valid), 1);
        check("rp_hit_flush", 32'(bus.flush), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rp_fc1", bus.fetch_count, 1);
        check("rp_rc0", bus.redirect_count, 0);

        // Counter wrap: preset the fetch counter to its maximum
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        #1;
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        check("wrap_fc_max", bus.fetch_count, 32'hFFFF_FFFF);
        check("wrap_fv", 32'(bus.fetch_valid), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("wrap_fc0", bus.fetch_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
